fpu16_issuer: RTL
=================

# fpu16_issuer

Sequencing initiator for the `fpu16` datapath. It accepts one FP16 operation at a time over a valid/ready request channel and drives `fpu16`'s operand, `op` and `start` inputs. For `FPU_MUL` it waits on `mulDone`. It captures result, condition codes, status flags and comparisons, and returns them over a valid/ready response channel. `fpu16` is instantiated beside this block, not inside it; this block is the only driver of its inputs.

## Interface
Parameters:
- `TAG_W`, 4: width of the opaque request tag, echoed on the response.
- `MUL_TIMEOUT`, 64: maximum number of `MUL_WAIT` cycles before the block aborts the operation. Legal range is 1..255.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: reset is synchronous and active-low. While low at an edge, the block enters the reset state.
- `reqValid` in 1, `reqReady` out 1: request handshake.
- `reqOp` in `fpuOp_t`; `reqA`, `reqB` in `fp16_t`; `reqTag` in `TAG_W`: request payload.
- `rspValid` out 1, `rspReady` in 1: response handshake.
- `rspResult` out `fp16_t`; `rspCond` out `condCode_t`; `rspStatus` out `statusFlag_t`; `rspComps` out `fpuComp_t`; `rspTag` out `TAG_W`; `rspErr` out 1: response payload.
- `fpuIn1`, `fpuIn2` out `fp16_t`; `fpuOp` out `fpuOp_t`; `fpuStart` out 1: drive `fpu16`.
- `fpuOut` in `fp16_t`; `fpuMulDone` in 1; `fpuCond` in `condCode_t`; `fpuStatus` in `statusFlag_t`; `fpuComps` in `fpuComp_t`: outputs from `fpu16`.

## Operation
- States: `IDLE`, `EXEC`, `MUL_START`, `MUL_WAIT`, `RESP`.
- `reqReady` = (state == `IDLE`). No request is accepted while the block is busy or holding a response.
- **Accept (IDLE):** a request is accepted when `reqValid && reqReady`. The block registers op, A, B and tag, then moves to:
  - `EXEC` for ADD or SUB;
  - `MUL_START` for MUL;
  - `RESP` for DIV, with no FPU access.
- **DIV:** `fpu16` has no divider yet. The response is result = `FP16_QNAN` (16'h7E00), status = NV only, cond = 0, comps = 0, `rspErr` = 0.
- **Operand drive:** `fpuIn1`, `fpuIn2` and `fpuOp` come from the registered request in every non-`IDLE` state. In `IDLE` they hold their last values; after reset they are 0 and `FPU_ADD`.
- **EXEC:** the block captures `fpuOut`, `fpuCond`, `fpuStatus` and `fpuComps` into the response registers, then moves to `RESP`.
- **MUL_START:** `fpuStart` = 1 for exactly this one cycle, then the block moves to `MUL_WAIT` and clears the timeout counter.
- **MUL_WAIT:**
  - If `fpuMulDone` = 1: capture the `fpu16` outputs and move to `RESP`.
  - Else, if the counter equals `MUL_TIMEOUT`−1: move to `RESP` with result = `FP16_QNAN`, status = NV, `rspErr` = 1.
  - Else: increment the counter.
  - `mulDone` arriving in the same cycle as the last count wins; no error is raised.
- `fpuMulDone` is ignored in every state except `MUL_WAIT`.
- **RESP:** `rspValid` = 1 and the payload is held stable until `rspReady`. On `rspValid && rspReady` the block returns to `IDLE`; `reqReady` rises on the following cycle.
- **Reset:** asserting reset in any state, including mid-`MUL_WAIT`, abandons the operation with no response. `fpuStart` is 0 in the reset cycle.

## Timing
- Reset values of all outputs:
  - `reqReady` = 1 (the block is in `IDLE`);
  - `rspValid`, `rspErr`, `fpuStart` = 0;
  - all payload outputs and `fpuIn1`/`fpuIn2` = 0;
  - `fpuOp` = `FPU_ADD`.
- Latencies, with the accept edge at cycle 0:
  - ADD/SUB: `rspValid` from cycle 2.
  - DIV: `rspValid` from cycle 1.
  - MUL: `fpuStart` high in cycle 1; with `mulDone` seen in cycle k, `rspValid` from cycle k+1.
  - MUL timeout: `rspValid` from cycle `MUL_TIMEOUT`+2.
- Peak throughput is one ADD/SUB every 3 cycles when `rspReady` is held at 1.
- All outputs are registered, except `reqReady`, which decodes directly from the state register.

## Structure
- Add to the shared constants package:
  - `issuerState_t` (enum of the five states);
  - `FP16_QNAN` = 16'h7E00.
- `fpuOp_t`, `fp16_t`, `condCode_t`, `statusFlag_t` and `fpuComp_t` already live there and are reused.
- The timeout counter width is $clog2(`MUL_TIMEOUT`+1).
- No sub-module; this is a single FSM plus capture registers.

## Test plan
- **ADD:** request ADD A=16'h3C00, B=16'h4000, tag 3, `rspReady`=1 → `rspValid` at cycle 2, result 16'h4200, tag 3, `rspErr` 0; `reqReady` low in cycles 1–2.
- **MUL:** request MUL A=16'h4000, B=16'h4200 → `fpuStart` pulses one cycle; the response follows `mulDone` by one cycle with result 16'h4600.
- **Backpressure:** SUB A=16'h4200, B=16'h3C00 with `rspReady`=0 for 5 cycles → payload 16'h4000 is stable throughout; `reqValid` held high is not accepted until the cycle after the handshake.
- **Timeout:** MUL with an `fpu16` model that never raises `mulDone`, `MUL_TIMEOUT`=8 → response at cycle 10, result 16'h7E00, NV set, `rspErr` 1. A second run with `mulDone` on the 8th `MUL_WAIT` cycle gives a normal result and `rspErr` 0.
- **DIV:** request DIV A=16'h3C00, B=16'h4000 → response at cycle 1, result 16'h7E00, NV set; `fpuStart` never asserted.
- **Reset mid-operation:** assert reset during `MUL_WAIT`, then a late `mulDone` arrives → no `rspValid`; all outputs return to reset values; the next ADD completes normally.

Source files
------------

// File: rtl/fpu16_issuer_pkg.sv
// Shared types and constants for the fpu16 datapath and the issuer that sequences it.
package fpu16_issuer_pkg;

   typedef logic [15:0] fp16_t;

   typedef enum logic [1:0] {
      FPU_ADD = 2'd0,
      FPU_SUB = 2'd1,
      FPU_MUL = 2'd2,
      FPU_DIV = 2'd3
   } fpuOp_t;

   typedef struct packed {
      logic neg;
      logic zero;
      logic inf;
      logic nan;
   } condCode_t;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } statusFlag_t;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
      logic un;
   } fpuComp_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      EXEC      = 3'd1,
      MUL_START = 3'd2,
      MUL_WAIT  = 3'd3,
      RESP      = 3'd4
   } issuerState_t;

   localparam fp16_t       FP16_QNAN      = 16'h7E00;
   localparam statusFlag_t STATUS_NV_ONLY = '{nv: 1'b1, default: 1'b0};

endpackage

// File: rtl/fpu16_issuer_if.sv
// Request and response channels between a client and fpu16_issuer.
interface fpu16_issuer_if
   import fpu16_issuer_pkg::*;
#(
   parameter int TAG_W = 4
);

   logic             reqValid;
   logic             reqReady;
   fpuOp_t           reqOp;
   fp16_t            reqA;
   fp16_t            reqB;
   logic [TAG_W-1:0] reqTag;

   logic             rspValid;
   logic             rspReady;
   fp16_t            rspResult;
   condCode_t        rspCond;
   statusFlag_t      rspStatus;
   fpuComp_t         rspComps;
   logic [TAG_W-1:0] rspTag;
   logic             rspErr;

   modport master (
      output reqValid, reqOp, reqA, reqB, reqTag, rspReady,
      input  reqReady, rspValid, rspResult, rspCond, rspStatus, rspComps, rspTag, rspErr
   );

   modport slave (
      input  reqValid, reqOp, reqA, reqB, reqTag, rspReady,
      output reqReady, rspValid, rspResult, rspCond, rspStatus, rspComps, rspTag, rspErr
   );

endinterface

// File: rtl/fpu16_issuer.sv
// Issues one FP16 operation at a time to an adjacent fpu16 and returns its result.
// MUL waits on mulDone with a bounded timeout; DIV is answered locally with a quiet NaN.
module fpu16_issuer
   import fpu16_issuer_pkg::*;
#(
   parameter int TAG_W       = 4,
   parameter int MUL_TIMEOUT = 64
)(
   input  logic        clock,
   input  logic        reset,
   fpu16_issuer_if.slave bus,
   output fp16_t       fpuIn1,
   output fp16_t       fpuIn2,
   output fpuOp_t      fpuOp,
   output logic        fpuStart,
   input  fp16_t       fpuOut,
   input  logic        fpuMulDone,
   input  condCode_t   fpuCond,
   input  statusFlag_t fpuStatus,
   input  fpuComp_t    fpuComps
);

   localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

   issuerState_t     state;
   fp16_t            a_q;
   fp16_t            b_q;
   fpuOp_t           op_q;
   logic [TAG_W-1:0] tag_q;
   logic             start_q;
   logic [CNT_W-1:0] wait_cnt;

   logic             rsp_valid;
   fp16_t            rsp_result;
   condCode_t        rsp_cond;
   statusFlag_t      rsp_status;
   fpuComp_t         rsp_comps;
   logic             rsp_err;

   // Operand registers double as the fpu16 drive, so they hold their value while idle.
   assign fpuIn1   = a_q;
   assign fpuIn2   = b_q;
   assign fpuOp    = op_q;
   assign fpuStart = start_q;

   assign bus.reqReady  = (state == IDLE);
   assign bus.rspValid  = rsp_valid;
   assign bus.rspResult = rsp_result;
   assign bus.rspCond   = rsp_cond;
   assign bus.rspStatus = rsp_status;
   assign bus.rspComps  = rsp_comps;
   assign bus.rspTag    = tag_q;
   assign bus.rspErr    = rsp_err;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= FPU_ADD;
         tag_q      <= '0;
         start_q    <= 1'b0;
         wait_cnt   <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_cond   <= '0;
         rsp_status <= '0;
         rsp_comps  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.reqValid) begin
                  a_q   <= bus.reqA;
                  b_q   <= bus.reqB;
                  op_q  <= bus.reqOp;
                  tag_q <= bus.reqTag;
                  case (bus.reqOp)
                     FPU_ADD, FPU_SUB: begin
                        state <= EXEC;
                     end
                     FPU_MUL: begin
                        state   <= MUL_START;
                        start_q <= 1'b1;
                     end
                     default: begin
                        // No divider in fpu16 yet: answer at once without touching it.
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= FP16_QNAN;
                        rsp_cond   <= '0;
                        rsp_status <= STATUS_NV_ONLY;
                        rsp_comps  <= '0;
                        rsp_err    <= 1'b0;
                     end
                  endcase
               end
            end

            EXEC: begin
               state      <= RESP;
               rsp_valid  <= 1'b1;
               rsp_result <= fpuOut;
               rsp_cond   <= fpuCond;
               rsp_status <= fpuStatus;
               rsp_comps  <= fpuComps;
               rsp_err    <= 1'b0;
            end

            MUL_START: begin
               state    <= MUL_WAIT;
               wait_cnt <= '0;
            end

            MUL_WAIT: begin
               // mulDone takes priority over the final timeout count.
               if (fpuMulDone) begin
                  state      <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_result <= fpuOut;
                  rsp_cond   <= fpuCond;
                  rsp_status <= fpuStatus;
                  rsp_comps  <= fpuComps;
                  rsp_err    <= 1'b0;
               end else if (wait_cnt == CNT_LAST) begin
                  state      <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_result <= FP16_QNAN;
                  rsp_cond   <= '0;
                  rsp_status <= STATUS_NV_ONLY;
                  rsp_comps  <= '0;
                  rsp_err    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            RESP: begin
               if (bus.rspReady) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
